// File: rtl/gf_reduce_seq_if.sv
// Operand/result handshake bundle for gf_reduce_seq: product and polynomial in,
// reduced field element out, each side with its own valid/ready pair.
interface gf_reduce_seq_if #(
  parameter int unsigned M = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [2*M-2:0] in;
  logic [M-1:0]   poly;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out;

  modport master (
    output in_valid, in, poly, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, poly, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/gf_reduce_seq.sv
// Sequential GF(2^M) reduction of a 2M-1 bit carry-less product, STEP high bits per clock.
// Optional GF_EARLY_EXIT_EN: finish as soon as no bits >= M remain.
module gf_reduce_seq #(
  parameter int unsigned M    = 8,
  parameter int unsigned STEP = 1
) (
  input logic            clk,
  input logic            rst_n,
  gf_reduce_seq_if.slave bus
);

  localparam int W    = 2 * int'(M) - 1;
  localparam int ITER = (int'(M) - 1 + int'(STEP) - 1) / int'(STEP);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic [W-1:0]   work_q;
  logic [W-1:0]   work_d;
  logic [M-1:0]   poly_q;
  logic [CW-1:0]  cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [M-1:0]   out_q;

  // One iteration: fold the current window of STEP bits, highest first, so a bit
  // raised by a higher fold is still seen lower in the same window.
  always_comb begin
    int           hi;
    logic [W-1:0] fold;
    work_d = work_q;
    hi     = (W - 1) - int'(cnt_q) * int'(STEP);
    fold   = W'({1'b1, poly_q});
    for (int k = W - 1; k >= int'(M); k--) begin
      if (k <= hi && k > hi - int'(STEP) && work_d[k]) begin
        work_d = work_d ^ (fold << (k - int'(M)));
      end
    end
  end

`ifdef GF_EARLY_EXIT_EN
  logic top_zero;
  assign top_zero = (work_q[W-1:M] == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      work_q      <= '0;
      poly_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            work_q     <= bus.in;
            poly_q     <= bus.poly;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
`ifdef GF_EARLY_EXIT_EN
          if (top_zero) begin
            out_q       <= work_q[M-1:0];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
`else
          begin
`endif
            work_q <= work_d;
            if (cnt_q == CW'(ITER - 1)) begin
              out_q       <= work_d[M-1:0];
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          // out_q is left untouched so the last result stays visible.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;

endmodule

// File: doc/gf_reduce_seq.md
Name: gf_reduce_seq

Overview:
Sequential, parametrised GF(2^M) polynomial reduction unit. It is the next generation of the combinational reduction block. It accepts a carry-less product of width 2M-1 and reduces it modulo a run-time irreducible polynomial, eliminating STEP high-order bits per clock. It sits between the GF multiplier array and the result register file, with valid/ready handshakes on both sides.

Parameters:
M, 8, field degree; output width M; product width 2M-1; legal range 2..32.
STEP, 1, high-order bits eliminated per clock; legal range 1..M-1.
ITER, ceil((M-1)/STEP), derived local parameter; number of reduction iterations (7 at defaults).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  product and poly are valid.
in_ready  output  1  unit can accept an operand.
in  input  2M-1  carry-less product, bit i = coefficient of x^i.
poly  input  M  low coefficients of the irreducible polynomial; x^M is implicit (0x1B = AES).
out_valid  output  1  reduced result is valid.
out_ready  input  1  consumer accepts the result.
out  output  M  reduced result, in mod (x^M + poly).

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE; in_ready=1; out_valid=0; out=0; working and poly registers cleared. Reset mid-operation drops the operation silently.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in into a 2M-1 working register and poly into a poly register, clear the iteration counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes working bits from the current top down, at most STEP bits.
  - For each bit k (k>=M) that is 1: working ^= ({1,poly} << (k-M)). Bits are processed serially within the cycle, highest first, so a bit set by a higher-bit fold is seen by the same cycle's lower-bit pass.
  - The last iteration processes only the remaining (M-1) mod STEP bits when STEP does not divide M-1. It never touches bits below M.
  - After ITER edges, go to DONE.
- DONE:
  - out_valid=1, out=working[M-1:0].
  - out is held stable while out_valid&&!out_ready.
  - On out_ready: go to IDLE, out_valid=0. out keeps its last value.
- Latency: out_valid rises exactly ITER edges after the accept edge (7 at defaults; 2 at M=8, STEP=4).
- Throughput: one operation per ITER+2 cycles minimum. There is no same-cycle turnaround; in_ready reasserts the cycle after the output handshake.
- Boundaries:
  - in_valid while busy is ignored; the producer must hold it.
  - poly changes after the accept edge have no effect.
  - in with no bits >= M is still iterated (no-op XORs) and gives out=in[M-1:0].
  - A non-irreducible poly is not checked; the arithmetic is still mod (x^M+poly).
  - out_ready high in IDLE or RUN has no effect.

Optional Feature:
Macro GF_EARLY_EXIT_EN.
- Defined: in RUN, if working[2M-2:M]==0 at the start of a cycle, go to DONE on that edge without further iterations. Latency is therefore 1..ITER edges and data-dependent.
- Undefined: latency is fixed at ITER edges for all inputs. No comparator logic is present.

Test Plan:
1. Reset: rst_n=0 mid-RUN (accept 0x2B79, assert reset after 3 edges) -> out_valid=0, in_ready=1, out=0 immediately; no result appears after release.
2. AES: M=8, STEP=1, poly=0x1B, in=0x2B79 (0x57*0x83) -> out=0xC1, out_valid exactly 7 edges after accept.
3. Single high term: in=0x4000 (x^14), poly=0x1B -> out=0x9A; in=0x0100 -> out=0x1B; both at 7 edges.
4. Backpressure: out_ready=0 for 5 cycles in DONE -> out stays 0xC1 and in_ready stays 0 with in_valid=1 and new data held; out_ready=1 -> next operand accepted the following cycle.
5. Multi-bit step: instance M=8, STEP=4 (ITER=2): in=0x2B79 -> 0xC1 after 2 edges. Instance M=8, STEP=3 (ITER=3, last step 1 bit): in=0x7FFF, poly=0x1B -> result matches the golden model (bit-serial reference); run 1000 random vectors against the model for both instances.
6. GF_EARLY_EXIT_EN: in=0x00FF -> out=0xFF after 1 edge (defined) vs 7 edges (undefined); in=0x2B79 -> 0xC1 within ≤7 edges in both builds.
